btn_step_gen: RTL and testbench

//   Upstream stage of the 4-bit counter. Turns a raw, bouncing push-button

---
 rtl/btn_step_gen.sv | 128 ++++++++++++
 tb/tb_btn_step_gen.sv | 108 ++++++++++
 2 files changed

// File: rtl/btn_step_gen.sv
// btn_step_gen: synchronise, debounce and edge-detect a raw push-button into a one-cycle step pulse.
// Optional auto-repeat while held is enabled by defining BTN_AUTOREPEAT_EN.
module btn_step_gen #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic step,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    logic          r_s1;
    logic          r_s2;
    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_step;
    logic          w_step_nxt;
    logic          r_level;
    logic          w_level_nxt;
    logic          w_rep_hit;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;
    localparam logic [RW-1:0] DLY_MAX = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_MAX = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] r_rcnt;
    logic          r_rep;

    assign w_rep_hit = (r_state == HELD) && r_s2 && (r_rcnt == (r_rep ? PER_MAX : DLY_MAX));

    // Repeat timing pauses in RELEASE_WAIT so a release glitch does not restart the delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rcnt <= '0;
            r_rep  <= 1'b0;
        end else if (r_state == HELD && r_s2) begin
            r_rcnt <= w_rep_hit ? '0 : r_rcnt + 1'b1;
            r_rep  <= r_rep | w_rep_hit;
        end else if (r_state == IDLE || r_state == PRESS_WAIT) begin
            r_rcnt <= '0;
            r_rep  <= 1'b0;
        end
    end
`else
    logic w_unused;
    assign w_unused  = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign w_rep_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_step  <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_s1    <= btn_raw;
            r_s2    <= r_s1;
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            r_step  <= w_step_nxt;
            r_level <= w_level_nxt;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_nxt   = r_cnt;
        w_step_nxt  = 1'b0;
        w_level_nxt = r_level;
        unique case (r_state)
            IDLE: begin
                w_next    = r_s2 ? PRESS_WAIT : IDLE;
                w_cnt_nxt = '0;
            end
            PRESS_WAIT: begin
                if (!r_s2) begin
                    w_next    = IDLE;
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_next      = HELD;
                    w_cnt_nxt   = '0;
                    w_step_nxt  = 1'b1;
                    w_level_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                w_next     = r_s2 ? HELD : RELEASE_WAIT;
                w_cnt_nxt  = '0;
                w_step_nxt = w_rep_hit;
            end
            RELEASE_WAIT: begin
                if (r_s2) begin
                    w_next    = HELD;
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_next      = IDLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_next    = IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    assign step  = r_step;
    assign level = r_level;
endmodule

// File: tb/tb_btn_step_gen.sv
// tb_btn_step_gen: directed checks of btn_step_gen with D=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
module tb_btn_step_gen;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_raw = 1'b0;
    logic step;
    logic level;
    int   n_chk = 0;
    int   n_err = 0;

    btn_step_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_raw),
        .step   (step),
        .level  (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input int e, input logic exp_step, input logic exp_level);
        @(posedge clk);
        #1;
        chk($sformatf("%s e%0d step", tag, e), step, exp_step);
        chk($sformatf("%s e%0d level", tag, e), level, exp_level);
    endtask

    task automatic idle(input string tag, input int n);
        btn_raw = 1'b0;
        for (int e = 1; e <= n; e++) cyc(tag, e, 1'b0, 1'b0);
    endtask

    initial begin
        // 1: outputs held low in reset regardless of input; quiet release
        for (int e = 1; e <= 6; e++) begin
            btn_raw = e[0];
            cyc("rst", e, 1'b0, 1'b0);
        end
        btn_raw = 1'b0;
        rst_n = 1'b1;
        idle("rst_rel", 10);

        // 2: clean press held 20 edges, then release
        for (int e = 1; e <= 30; e++) begin
            btn_raw = (e <= 20);
            cyc("press", e, (e == 7) || (AR && e >= 15 && e <= 22 && (e - 15) % 3 == 0),
                (e >= 7) && (e < 27));
        end
        idle("gap2", 4);

        // 3: bounce, every high run too short to be accepted
        for (int e = 1; e <= 15; e++) begin
            btn_raw = (e <= 2) || (e >= 4 && e <= 6);
            cyc("bounce", e, 1'b0, 1'b0);
        end
        idle("gap3", 4);

        // 4: two-cycle low glitch while held
        for (int e = 1; e <= 30; e++) begin
            btn_raw = (e <= 10) || (e >= 13 && e <= 20);
            cyc("glitch", e, (e == 7) || (AR && (e == 18 || e == 21)), (e >= 7) && (e < 27));
        end
        idle("gap4", 4);

        // 5: reset during PRESS_WAIT discards the press; held button re-accepted
        btn_raw = 1'b1;
        for (int e = 1; e <= 5; e++) cyc("pre_rst", e, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_rst step", step, 1'b0);
        chk("async_rst level", level, 1'b0);
        for (int e = 1; e <= 2; e++) cyc("in_rst", e, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) cyc("post_rst", e, e == 7, e >= 7);
        btn_raw = 1'b0;
        for (int e = 1; e <= 10; e++) cyc("post_rel", e, 1'b0, e < 7);
        idle("gap5", 4);

        // 6: long hold, auto-repeat cadence when enabled
        for (int e = 1; e <= 40; e++) begin
            btn_raw = (e <= 30);
            cyc("hold", e, (e == 7) || (AR && e >= 15 && e <= 30 && (e - 15) % 3 == 0),
                (e >= 7) && (e < 37));
        end
        idle("tail", 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
